// File: rtl/run_control.sv
// Run/termination controller: watches per-core done lines, counts cycles, ends the run by done+drain or by budget expiry.
// Latency: status outputs decode the registered state; done_mask/first_id/cycle_count update on the sampling edge.
// Backpressure: none; inputs are levels sampled every edge, outputs are levels held until reset.
//
// Optional feature macro: RUN_CONTROL_STAMP_EN (adds stamp_sel_i / stamp_o per-channel completion stamps).
//
// Ports:
//   clk_i          system clock
//   reset_ni       asynchronous active-low reset (0 = in reset)
//   done_i         per-core done levels
//   en_mask_i      channel enables; disabled channels are ignored
//   all_mode_i     1 = wait for all enabled channels, 0 = any enabled channel
//   max_count_i    cycle budget, 0 disables timeout
//   finish_o       run ended (sticky)
//   pass_o         ended by the done condition
//   timeout_o      ended by budget expiry
//   cycle_count_o  cycles elapsed since RUN entry (saturating)
//   done_mask_o    sticky per-channel completion
//   first_id_o     lowest channel completing on the earliest completing edge
//   busy_o         state is RUN or DRAIN
//   stamp_sel_i    (optional) channel select for stamp_o
//   stamp_o        (optional) cycle stamp of the selected channel's completion
module run_control #(
    parameter int NCH          = 4,
    parameter int CW           = 32,
    parameter int DRAIN_CYCLES = 8,
    parameter int IW           = 2
) (
    input  logic           clk_i,
    input  logic           reset_ni,
    input  logic [NCH-1:0] done_i,
    input  logic [NCH-1:0] en_mask_i,
    input  logic           all_mode_i,
    input  logic [CW-1:0]  max_count_i,
`ifdef RUN_CONTROL_STAMP_EN
    input  logic [IW-1:0]  stamp_sel_i,
    output logic [CW-1:0]  stamp_o,
`endif
    output logic           finish_o,
    output logic           pass_o,
    output logic           timeout_o,
    output logic [CW-1:0]  cycle_count_o,
    output logic [NCH-1:0] done_mask_o,
    output logic [IW-1:0]  first_id_o,
    output logic           busy_o
);

    // Drain counter only needs to reach DRAIN_CYCLES-1; keep at least one bit.
    localparam int DW    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int DLAST = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_DRAIN = 3'd2,
        S_DONE  = 3'd3,
        S_TOUT  = 3'd4
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cycle_count_q, cycle_count_d;
    logic [DW-1:0]  drain_q, drain_d;
    logic [NCH-1:0] done_mask_q, done_mask_d;
    logic [IW-1:0]  first_id_q, first_id_d;

    logic [NCH-1:0] hit;
    logic [NCH-1:0] nxt;
    logic           cond;
    logic [CW-1:0]  cnt_inc;
    logic [IW-1:0]  low_id;
    logic           active;

    assign hit     = done_i & en_mask_i;
    assign nxt     = done_mask_q | hit;
    assign active  = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign cnt_inc = (&cycle_count_q) ? cycle_count_q : cycle_count_q + CW'(1);

    // An all-zero enable mask can never complete in either mode.
    always_comb begin
        cond = 1'b0;
        if (all_mode_i) begin
            cond = (en_mask_i != '0) && (&(nxt | ~en_mask_i));
        end else begin
            cond = |(nxt & en_mask_i);
        end
    end

    // Priority pick: scan from the top so the lowest set index wins.
    always_comb begin
        low_id = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (hit[i]) begin
                low_id = IW'(i);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        cycle_count_d = cycle_count_q;
        drain_d       = drain_q;
        done_mask_d   = done_mask_q;
        first_id_d    = first_id_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                cycle_count_d = cnt_inc;
                done_mask_d   = nxt;
                if ((done_mask_q == '0) && (hit != '0)) begin
                    first_id_d = low_id;
                end
                // Completion takes priority over a budget expiring on the same edge.
                if (cond) begin
                    drain_d = '0;
                    state_d = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
                end else if ((max_count_i != '0) && (cnt_inc == max_count_i)) begin
                    state_d = S_TOUT;
                end
            end
            S_DRAIN: begin
                cycle_count_d = cnt_inc;
                done_mask_d   = nxt;
                if (drain_q == DW'(DLAST)) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            default: begin
                // DONE and TOUT are terminal until reset.
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q       <= S_IDLE;
            cycle_count_q <= '0;
            drain_q       <= '0;
            done_mask_q   <= '0;
            first_id_q    <= '0;
        end else begin
            state_q       <= state_d;
            cycle_count_q <= cycle_count_d;
            drain_q       <= drain_d;
            done_mask_q   <= done_mask_d;
            first_id_q    <= first_id_d;
        end
    end

    assign finish_o      = (state_q == S_DONE) || (state_q == S_TOUT);
    assign pass_o        = (state_q == S_DONE);
    assign timeout_o     = (state_q == S_TOUT);
    assign busy_o        = active;
    assign cycle_count_o = cycle_count_q;
    assign done_mask_o   = done_mask_q;
    assign first_id_o    = first_id_q;

`ifdef RUN_CONTROL_STAMP_EN
    // Each stamp records the cycle_count value that the setting edge produces.
    logic [CW-1:0] stamp_q [NCH];

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int i = 0; i < NCH; i++) begin
                stamp_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (active && hit[i] && !done_mask_q[i]) begin
                    stamp_q[i] <= cnt_inc;
                end
            end
        end
    end

    always_comb begin
        stamp_o = '0;
        if (int'(stamp_sel_i) < NCH) begin
            stamp_o = stamp_q[stamp_sel_i];
        end
    end
`endif

endmodule

// File: tb/tb_run_control.sv
module tb_run_control;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance: default parameters (DRAIN_CYCLES = 8).
    logic        a_rst_n;
    logic [3:0]  a_done, a_en;
    logic        a_all;
    logic [31:0] a_max;
    logic        a_finish, a_pass, a_tout, a_busy;
    logic [31:0] a_cnt;
    logic [3:0]  a_mask;
    logic [1:0]  a_fid;

    // Second instance with no drain period.
    logic        b_rst_n;
    logic [3:0]  b_done, b_en;
    logic        b_all;
    logic [31:0] b_max;
    logic        b_finish, b_pass, b_tout, b_busy;
    logic [31:0] b_cnt;
    logic [3:0]  b_mask;
    logic [1:0]  b_fid;

`ifdef RUN_CONTROL_STAMP_EN
    logic [1:0]  a_sel, b_sel;
    logic [31:0] a_stamp, b_stamp;
`endif

    int checks = 0;
    int errors = 0;

    run_control #(.NCH(4), .CW(32), .DRAIN_CYCLES(8), .IW(2)) dut (
        .clk_i        (clk),
        .reset_ni     (a_rst_n),
        .done_i       (a_done),
        .en_mask_i    (a_en),
        .all_mode_i   (a_all),
        .max_count_i  (a_max),
`ifdef RUN_CONTROL_STAMP_EN
        .stamp_sel_i  (a_sel),
        .stamp_o      (a_stamp),
`endif
        .finish_o     (a_finish),
        .pass_o       (a_pass),
        .timeout_o    (a_tout),
        .cycle_count_o(a_cnt),
        .done_mask_o  (a_mask),
        .first_id_o   (a_fid),
        .busy_o       (a_busy)
    );

    run_control #(.NCH(4), .CW(32), .DRAIN_CYCLES(0), .IW(2)) dut_z (
        .clk_i        (clk),
        .reset_ni     (b_rst_n),
        .done_i       (b_done),
        .en_mask_i    (b_en),
        .all_mode_i   (b_all),
        .max_count_i  (b_max),
`ifdef RUN_CONTROL_STAMP_EN
        .stamp_sel_i  (b_sel),
        .stamp_o      (b_stamp),
`endif
        .finish_o     (b_finish),
        .pass_o       (b_pass),
        .timeout_o    (b_tout),
        .cycle_count_o(b_cnt),
        .done_mask_o  (b_mask),
        .first_id_o   (b_fid),
        .busy_o       (b_busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // Hold reset for two cycles with the given run setup, then release on a falling edge.
    task automatic a_start(input logic [3:0] en, input logic all, input logic [31:0] max);
        a_rst_n = 1'b0;
        a_done  = 4'b0000;
        a_en    = en;
        a_all   = all;
        a_max   = max;
        repeat (2) @(negedge clk);
        a_rst_n = 1'b1;
    endtask

    // Advance until cycle_count shows target; inputs changed afterwards land on the edge producing target+1.
    task automatic a_wait_count(input string tag, input logic [31:0] target);
        int n = 0;
        while (a_cnt != target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " reach"}, a_cnt, target);
    endtask

    task automatic a_wait_finish(input string tag);
        int n = 0;
        while (!a_finish && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " finish"}, a_finish, 1);
    endtask

    initial begin
        a_rst_n = 1'b0; a_done = '0; a_en = '0; a_all = 1'b0; a_max = '0;
        b_rst_n = 1'b0; b_done = '0; b_en = '0; b_all = 1'b0; b_max = '0;
`ifdef RUN_CONTROL_STAMP_EN
        a_sel = '0; b_sel = '0;
`endif
        @(negedge clk);
        chk("rst finish", a_finish, 0);
        chk("rst busy",   a_busy,   0);
        chk("rst count",  a_cnt,    0);
        chk("rst mask",   a_mask,   0);
        chk("rst fid",    a_fid,    0);

        // 1: all-mode, four channels staggered.
        a_start(4'b1111, 1'b1, 32'd0);
        @(negedge clk);
        chk("t1 busy first", a_busy, 1);
        chk("t1 count first", a_cnt, 0);
        a_wait_count("t1 c9", 9);   a_done[2] = 1'b1;
        @(negedge clk);
        chk("t1 mask10", a_mask, 4'b0100);
        chk("t1 fid10",  a_fid,  2);
        a_wait_count("t1 c19", 19); a_done[0] = 1'b1;
        a_wait_count("t1 c29", 29); a_done[1] = 1'b1;
        a_wait_count("t1 c39", 39); a_done[3] = 1'b1;
        @(negedge clk);
        chk("t1 drain busy",  a_busy,   1);
        chk("t1 drain fin",   a_finish, 0);
        chk("t1 drain count", a_cnt,    40);
        chk("t1 drain mask",  a_mask,   4'b1111);
        a_wait_count("t1 c47", 47);
        chk("t1 fin47", a_finish, 0);
        a_wait_finish("t1");
        chk("t1 count", a_cnt,  48);
        chk("t1 pass",  a_pass, 1);
        chk("t1 tout",  a_tout, 0);
        chk("t1 busy",  a_busy, 0);
        chk("t1 fid",   a_fid,  2);
        repeat (5) @(negedge clk);
        chk("t1 frozen", a_cnt, 48);
`ifdef RUN_CONTROL_STAMP_EN
        a_sel = 2'd0; #1 chk("t1 stamp0", a_stamp, 20);
        a_sel = 2'd1; #1 chk("t1 stamp1", a_stamp, 30);
        a_sel = 2'd2; #1 chk("t1 stamp2", a_stamp, 10);
        a_sel = 2'd3; #1 chk("t1 stamp3", a_stamp, 40);
`endif

        // 2: any-mode, disabled channel ignored.
        a_start(4'b0110, 1'b0, 32'd0);
        a_wait_count("t2 c4", 4);   a_done[0] = 1'b1;
        @(negedge clk);
        chk("t2 mask masked", a_mask, 4'b0000);
        chk("t2 busy",        a_busy, 1);
        a_wait_count("t2 c11", 11); a_done[1] = 1'b1;
        @(negedge clk);
        chk("t2 mask", a_mask, 4'b0010);
        chk("t2 fid",  a_fid,  1);
        a_wait_finish("t2");
        chk("t2 count", a_cnt,  20);
        chk("t2 pass",  a_pass, 1);
        chk("t2 mask end", a_mask, 4'b0010);

        // 3: budget expiry with no done.
        a_start(4'b1111, 1'b1, 32'd100);
        a_wait_count("t3 c99", 99);
        chk("t3 tout99", a_tout, 0);
        @(negedge clk);
        chk("t3 tout",  a_tout,   1);
        chk("t3 fin",   a_finish, 1);
        chk("t3 pass",  a_pass,   0);
        chk("t3 count", a_cnt,    100);
        repeat (50) @(negedge clk);
        chk("t3 hold count", a_cnt,    100);
        chk("t3 hold tout",  a_tout,   1);
        chk("t3 hold fin",   a_finish, 1);
        chk("t3 hold pass",  a_pass,   0);

        // 4: completion and budget on the same edge; completion wins.
        a_start(4'b1111, 1'b1, 32'd50);
        a_wait_count("t4 c9", 9);   a_done = 4'b0111;
        a_wait_count("t4 c49", 49); a_done[3] = 1'b1;
        @(negedge clk);
        chk("t4 busy",  a_busy, 1);
        chk("t4 tout",  a_tout, 0);
        chk("t4 count", a_cnt,  50);
        a_wait_finish("t4");
        chk("t4 pass",    a_pass, 1);
        chk("t4 tout end", a_tout, 0);
        chk("t4 count end", a_cnt, 58);

        // 5: asynchronous reset during drain, then a fresh run.
        a_start(4'b0001, 1'b0, 32'd0);
        a_wait_count("t5 c19", 19); a_done[0] = 1'b1;
        a_wait_count("t5 c25", 25);
        chk("t5 in drain", a_busy, 1);
        #2 a_rst_n = 1'b0;
        #1;
        chk("t5 rst busy",  a_busy,   0);
        chk("t5 rst fin",   a_finish, 0);
        chk("t5 rst count", a_cnt,    0);
        chk("t5 rst mask",  a_mask,   0);
        repeat (3) @(negedge clk);
        a_start(4'b1111, 1'b0, 32'd0);
        a_wait_count("t5 c2", 2);   a_done[3] = 1'b1;
        @(negedge clk);
        chk("t5 mask",  a_mask, 4'b1000);
        chk("t5 fid",   a_fid,  3);
        chk("t5 count", a_cnt,  3);
        a_wait_finish("t5");
        chk("t5 count end", a_cnt,  11);
        chk("t5 pass",      a_pass, 1);

        // 6: zero drain, empty enable mask: only timeout can end the run.
        b_en = 4'b0000; b_all = 1'b1; b_max = 32'd20; b_done = 4'b1111;
        @(negedge clk);
        b_rst_n = 1'b1;
        begin
            int n = 0;
            while (!b_finish && n < 200) begin
                @(negedge clk);
                n++;
            end
        end
        chk("t6 fin",   b_finish, 1);
        chk("t6 tout",  b_tout,   1);
        chk("t6 pass",  b_pass,   0);
        chk("t6 count", b_cnt,    20);
        chk("t6 mask",  b_mask,   0);

        // Zero drain with done already high: DONE on the first RUN edge.
        b_rst_n = 1'b0; b_en = 4'b0011; b_max = 32'd0;
        @(negedge clk);
        b_rst_n = 1'b1;
        @(negedge clk);
        chk("t6b busy",  b_busy, 1);
        chk("t6b count0", b_cnt, 0);
        @(negedge clk);
        chk("t6b pass",  b_pass,   1);
        chk("t6b fin",   b_finish, 1);
        chk("t6b count", b_cnt,    1);
        chk("t6b mask",  b_mask,   4'b0011);
        chk("t6b fid",   b_fid,    0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
